alu_share_sequencer: RTL and testbench



---
 rtl/alu_share_sequencer_if.sv | 44 ++++
 rtl/alu_share_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_share_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_sequencer_if.sv
// rtl/alu_share_sequencer_if.sv - requester and ALU side signals of the shared ALU sequencer
interface alu_share_sequencer_if;
    logic        req0_valid;
    logic [1:0]  req0_op;
    logic [7:0]  req0_x;
    logic [7:0]  req0_y;
    logic        req0_ready;
    logic        resp0_valid;
    logic [15:0] resp0_data;
    logic        resp0_err;
    logic        req1_valid;
    logic [1:0]  req1_op;
    logic [7:0]  req1_x;
    logic [7:0]  req1_y;
    logic        req1_ready;
    logic        resp1_valid;
    logic [15:0] resp1_data;
    logic        resp1_err;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic        alu_reset;
    logic [7:0]  alu_outbus;
    logic        alu_end;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        input  req1_valid, req1_op, req1_x, req1_y,
        input  alu_outbus, alu_end,
        output req0_ready, resp0_valid, resp0_data, resp0_err,
        output req1_ready, resp1_valid, resp1_data, resp1_err,
        output alu_begin, alu_op_code, alu_inbus, alu_reset, busy
    );

    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        output req1_valid, req1_op, req1_x, req1_y,
        output alu_outbus, alu_end,
        input  req0_ready, resp0_valid, resp0_data, resp0_err,
        input  req1_ready, resp1_valid, resp1_data, resp1_err,
        input  alu_begin, alu_op_code, alu_inbus, alu_reset, busy
    );
endinterface

// File: rtl/alu_share_sequencer.sv
// rtl/alu_share_sequencer.sv - round-robin sharing of one serial-load ALU between two requesters
module alu_share_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  reset,
    alu_share_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD_X, S_LOAD_Y, S_WAIT, S_CAPT, S_RESP
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [1:0]  r_op;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_cnt;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_err;

    state_t      w_state_nxt;
    logic        w_grant_en;
    logic        w_grant_sel;
    logic        w_cap_hi;
    logic        w_cap_lo;
    logic        w_clr_hi;
    logic        w_abort;
    logic        w_begin;
    logic [7:0]  w_inbus;
    logic        w_op_active;
    logic        w_resp0;
    logic        w_resp1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_grant_sel = 1'b0;
        w_cap_hi    = 1'b0;
        w_cap_lo    = 1'b0;
        w_clr_hi    = 1'b0;
        w_abort     = 1'b0;
        w_begin     = 1'b0;
        w_inbus     = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    w_grant_en  = 1'b1;
                    // On a tie the requester that did not win last time goes first
                    w_grant_sel = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_begin     = 1'b1;
                w_state_nxt = S_LOAD_X;
            end
            S_LOAD_X: begin
                w_inbus     = r_x;
                w_state_nxt = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                w_inbus     = r_y;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_end) begin
                    if (r_op[1]) begin
                        w_cap_hi    = 1'b1;
                        w_state_nxt = S_CAPT;
                    end else begin
                        w_cap_lo    = 1'b1;
                        w_clr_hi    = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_CAPT: begin
                if (bus.alu_end) begin
                    w_cap_lo = 1'b1;
                end else begin
                    w_abort  = 1'b1;
                end
                w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op         <= 2'b00;
            r_x          <= 8'h00;
            r_y          <= 8'h00;
            r_cnt        <= 8'h00;
            r_hi         <= 8'h00;
            r_lo         <= 8'h00;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_en) begin
                r_grant      <= w_grant_sel;
                r_last_grant <= w_grant_sel;
                r_op         <= w_grant_sel ? bus.req1_op : bus.req0_op;
                r_x          <= w_grant_sel ? bus.req1_x  : bus.req0_x;
                r_y          <= w_grant_sel ? bus.req1_y  : bus.req0_y;
                r_err        <= 1'b0;
            end
            if (r_state == S_LOAD_Y) begin
                r_cnt <= 8'h00;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_abort) begin
                r_hi  <= 8'h00;
                r_lo  <= 8'h00;
                r_err <= 1'b1;
            end else begin
                if (w_cap_hi) begin
                    r_hi <= bus.alu_outbus;
                end
                if (w_cap_lo) begin
                    r_lo  <= bus.alu_outbus;
                    r_err <= 1'b0;
                end
                if (w_clr_hi) begin
                    r_hi <= 8'h00;
                end
            end
        end
    end

    assign w_op_active = (r_state == S_START) || (r_state == S_LOAD_X) || (r_state == S_LOAD_Y) ||
                         (r_state == S_WAIT)  || (r_state == S_CAPT);
    assign w_resp0     = (r_state == S_RESP) && !r_grant;
    assign w_resp1     = (r_state == S_RESP) &&  r_grant;

    assign bus.req0_ready  = w_grant_en && !w_grant_sel && !reset;
    assign bus.req1_ready  = w_grant_en &&  w_grant_sel && !reset;
    assign bus.resp0_valid = w_resp0;
    assign bus.resp0_data  = w_resp0 ? {r_hi, r_lo} : 16'h0000;
    assign bus.resp0_err   = w_resp0 && r_err;
    assign bus.resp1_valid = w_resp1;
    assign bus.resp1_data  = w_resp1 ? {r_hi, r_lo} : 16'h0000;
    assign bus.resp1_err   = w_resp1 && r_err;
    assign bus.alu_begin   = w_begin;
    assign bus.alu_op_code = w_op_active ? r_op : 2'b00;
    assign bus.alu_inbus   = w_inbus;
    assign bus.alu_reset   = reset || w_abort;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_sequencer.sv
// tb/tb_alu_share_sequencer.sv - randomized self-checking bench for alu_share_sequencer
module tb_alu_share_sequencer;
    localparam int T = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_last;

    alu_share_sequencer_if bus();

    alu_share_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_result(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'd0:    return {8'h00, 8'(x + y)};
            2'd1:    return {8'h00, 8'(x - y)};
            2'd2:    return 16'(x * y);
            default: return {8'(x % y), 8'(x / y)};
        endcase
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_op = 0; bus.req0_x = 0; bus.req0_y = 0;
        bus.req1_op = 0; bus.req1_x = 0; bus.req1_y = 0;
        bus.alu_end = 0; bus.alu_outbus = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        #1 chk_eq("rst_alu_reset", 32'(bus.alu_reset), 1);
        @(negedge clk);
        #1;
        chk_eq("rst_busy", 32'(bus.busy), 0);
        chk_eq("rst_outs", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid,
                            bus.alu_begin, bus.alu_op_code, bus.alu_inbus}, 0);
        @(negedge clk);
        reset = 0;
        m_last = 1;
    endtask

    // mode: 0 normal, 1 ALU never answers, 2 second result byte missing
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [1:0] op0, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [1:0] op1, input logic [7:0] x1, input logic [7:0] y1,
                           input int d, input int mode_in);
        bit          win;
        bit          two;
        int          mode;
        int          end_c;
        int          resp_c;
        int          abort_c;
        logic [1:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] res;
        logic [15:0] exp_data;
        bit          exp_err;

        win  = (v0 && v1) ? !m_last : v1;
        m_last = win;
        op   = win ? op1 : op0;
        x    = win ? x1 : x0;
        y    = win ? y1 : y0;
        two  = op[1];
        mode = (mode_in == 2 && !two) ? 0 : mode_in;
        res  = alu_result(op, x, y);
        end_c = 4 + d;
        abort_c = -1;
        if (mode == 1) begin
            abort_c = 4 + T - 1;
            resp_c  = abort_c + 1;
        end else if (!two) begin
            resp_c = end_c + 1;
        end else begin
            resp_c = end_c + 2;
            if (mode == 2) abort_c = end_c + 1;
        end
        exp_err  = (mode != 0);
        exp_data = exp_err ? 16'h0000 : res;

        for (int c = 0; c <= resp_c + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.req0_valid = v0; bus.req0_op = op0; bus.req0_x = x0; bus.req0_y = y0;
                bus.req1_valid = v1; bus.req1_op = op1; bus.req1_x = x1; bus.req1_y = y1;
            end else begin
                bus.req0_valid = 0;
                bus.req1_valid = 0;
            end
            bus.alu_outbus = 8'($urandom);
            bus.alu_end    = (c < 4 || c >= resp_c) ? 1'($urandom) : 1'b0;
            if (mode != 1 && c == end_c) begin
                bus.alu_end    = 1;
                bus.alu_outbus = two ? res[15:8] : res[7:0];
            end
            if (two && mode == 0 && c == end_c + 1) begin
                bus.alu_end    = 1;
                bus.alu_outbus = res[7:0];
            end
            #1;
            if (c == 0) begin
                chk_eq("ready0", 32'(bus.req0_ready), 32'(!win));
                chk_eq("ready1", 32'(bus.req1_ready), 32'(win));
            end
            if (c == 1) begin
                chk_eq("begin", 32'(bus.alu_begin), 1);
                chk_eq("op_code", 32'(bus.alu_op_code), 32'(op));
                chk_eq("inbus_start", 32'(bus.alu_inbus), 0);
            end
            if (c == 2) chk_eq("inbus_x", {bus.alu_begin, bus.alu_inbus}, {1'b0, x});
            if (c == 3) chk_eq("inbus_y", {bus.alu_op_code, bus.alu_inbus}, {op, y});
            chk_eq("alu_reset", 32'(bus.alu_reset), 32'(c == abort_c));
            chk_eq("resp_valid", {bus.resp0_valid, bus.resp1_valid},
                   {c == resp_c && !win, c == resp_c && win});
            if (c == resp_c) begin
                chk_eq("resp_data", win ? bus.resp1_data : bus.resp0_data, exp_data);
                chk_eq("resp_err", win ? bus.resp1_err : bus.resp0_err, exp_err);
                chk_eq("other_quiet", win ? {bus.resp0_data, bus.resp0_err} : {bus.resp1_data, bus.resp1_err}, 0);
                chk_eq("busy_resp", 32'(bus.busy), 1);
            end
            if (c == resp_c + 1) chk_eq("busy_after", 32'(bus.busy), 0);
        end
        bus.alu_end = 0;
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        bus.req1_valid = 1; bus.req1_op = 2'd2; bus.req1_x = 8'h33; bus.req1_y = 8'h44;
        #1 chk_eq("mid_ready1", 32'(bus.req1_ready), 1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.req1_valid = 0;
            bus.alu_end    = 0;
        end
        @(negedge clk);
        reset = 1;
        #1 chk_eq("mid_alu_reset", 32'(bus.alu_reset), 1);
        @(negedge clk);
        reset = 0;
        #1 chk_eq("mid_busy", 32'(bus.busy), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.alu_end    = 1;
            bus.alu_outbus = 8'($urandom);
            #1 chk_eq("mid_no_resp", {bus.resp0_valid, bus.resp1_valid, bus.busy}, 0);
        end
        bus.alu_end = 0;
        m_last = 1;
    endtask

    initial begin
        bit         v0;
        bit         v1;
        logic [1:0] o0;
        logic [1:0] o1;
        int         md;

        reset = 1;
        idle_inputs();
        do_reset();

        run_txn(1, 0, 2'd0, 8'h12, 8'h34, 2'd0, 8'h00, 8'h00, 4, 0);
        run_txn(1, 0, 2'd0, 8'hF0, 8'h20, 2'd0, 8'h00, 8'h00, T - 1, 0);

        do_reset();
        for (int i = 0; i < 3; i++)
            run_txn(1, 1, 2'd1, 8'h50, 8'h21, 2'd1, 8'h05, 8'h09, 2, 0);

        run_txn(0, 1, 2'd0, 8'h00, 8'h00, 2'd2, 8'h10, 8'h20, 0, 0);
        run_txn(1, 0, 2'd3, 8'h64, 8'h07, 2'd0, 8'h00, 8'h00, 0, 1);
        run_txn(1, 0, 2'd2, 8'h0F, 8'h0F, 2'd0, 8'h00, 8'h00, 1, 2);

        reset_mid_wait();
        run_txn(1, 0, 2'd0, 8'h01, 8'h02, 2'd0, 8'h00, 8'h00, 3, 0);

        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1;
            o0 = 2'($urandom);
            o1 = 2'($urandom);
            md = $urandom_range(0, 7);
            md = (md == 0) ? 1 : (md == 1) ? 2 : 0;
            run_txn(v0, v1, o0, 8'($urandom), 8'($urandom_range(1, 255)),
                    o1, 8'($urandom), 8'($urandom_range(1, 255)),
                    $urandom_range(0, T - 1), md);
            for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
